project1_unit: RTL and testbench
================================

// Module: project1_unit
// PURPOSE
//   3-input Boolean function unit: samples inputs x, y, z and drives out = F(x,y,z).
//   F is set by an 8-entry truth-table parameter; default is 3-input majority.
//   Leaf block; used stand-alone or as a voting/decision cell in larger datapaths.
//   Result is registered: one clock of latency, synchronous active-high reset.
// PARAMETERS
//   TRUTH_TABLE  8'b1110_1000  bit i = out for index i = {x,y,z}
//                              (x is MSB); default = majority
//   REG_OUT      1             1: registered out (1-cycle latency); 0: out combinational,
//                              out_valid still registered
// PORTS
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous, active-high reset
//   x          in   1  function input, index bit 2
//   y          in   1  function input, index bit 1
//   z          in   1  function input, index bit 0
//   in_valid   in   1  inputs qualified this cycle; tie high for free-running use
//   out        out  1  F(x,y,z)
//   out_valid  out  1  out holds a result computed from qualified inputs
// BEHAVIOUR
//   - Clock and reset: one clock (clk); rst is synchronous and active-high, sampled on
//     the rising edge of clk; no asynchronous reset path.
//   - Reset: while rst=1 at a clk edge, out<=0 and out_valid<=0. rst overrides in_valid.
//   - Reset mid-operation: any pending result is discarded. The first valid result
//     appears one cycle after the first in_valid=1 edge with rst=0.
//   - Index: idx = {x,y,z} (3 bits, 0..7). f = TRUTH_TABLE[idx].
//   - REG_OUT=1, edge with rst=0 and in_valid=1: out<=f, out_valid<=1.
//   - REG_OUT=1, edge with rst=0 and in_valid=0: out holds its last value, out_valid<=0.
//   - REG_OUT=0: out = f at all times (combinational); out_valid is registered as above.
//   - Default truth table (majority):
//       idx 0..7 -> 0,0,0,1,0,1,1,1
//       i.e. out=1 when at least two of x, y, z are 1.
//   - X/Z on any input with in_valid=1: out may be X; no X-suppression logic.
//   - Back-to-back valid inputs: one result per cycle, no stalls, no backpressure.
// STRUCTURE
//   - Shared package project1_pkg:
//       localparam TT_MAJORITY=8'hE8, TT_XOR3=8'h96, TT_AND3=8'h80, TT_OR3=8'hFE
//       function automatic tt_eval(input [7:0] tt, input [2:0] idx)
//   - No sub-modules. One combinational lookup plus one output register stage
//     (out, out_valid).
// TESTING
//   1. rst=1 for 2 cycles with x=y=z=1 and in_valid=1 -> out=0, out_valid=0 throughout.
//   2. Default table; sweep idx 0..7 (k -> x=k[2], y=k[1], z=k[0]), one per cycle,
//      in_valid=1 -> out sequence 0,0,0,1,0,1,1,1, each one cycle after its input.
//   3. in_valid=1 with idx=7, then in_valid=0 with idx=0 -> out stays 1, out_valid drops to 0.
//   4. Assert rst for one cycle in the middle of the sweep -> next cycle out=0, out_valid=0;
//      sweep resumes with 1-cycle latency.
//   5. TRUTH_TABLE=TT_XOR3, sweep 0..7 -> out 0,1,1,0,1,0,0,1.
//   6. REG_OUT=0, idx=3 -> out=1 in the same cycle; out_valid rises at the next edge.

Source files
------------

// File: rtl/project1_pkg.sv
// Shared definitions for the 3-input Boolean function unit: common truth tables
// and the table-lookup helper used by project1_unit.
package project1_pkg;

    localparam int unsigned TT_W  = 8;
    localparam int unsigned IDX_W = 3;

    // Truth tables, bit i = result for idx i = {x,y,z}
    localparam logic [TT_W-1:0] TT_MAJORITY = 8'hE8;
    localparam logic [TT_W-1:0] TT_XOR3     = 8'h96;
    localparam logic [TT_W-1:0] TT_AND3     = 8'h80;
    localparam logic [TT_W-1:0] TT_OR3      = 8'hFE;

    // Look up one truth-table entry
    function automatic logic tt_eval(input logic [TT_W-1:0] tt, input logic [IDX_W-1:0] idx);
        return tt[idx];
    endfunction

endpackage

// File: rtl/project1_unit.sv
// 3-input Boolean function unit: out = TRUTH_TABLE[{x,y,z}].
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   x, y, z    function inputs (x is index MSB)
//   in_valid   inputs qualified this cycle
//   out        F(x,y,z); registered when REG_OUT=1, combinational when REG_OUT=0
//   out_valid  registered; high one cycle after a qualified input
module project1_unit
    import project1_pkg::*;
#(
    parameter logic [TT_W-1:0] TRUTH_TABLE = TT_MAJORITY,
    parameter bit              REG_OUT     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    input  logic y,
    input  logic z,
    input  logic in_valid,
    output logic out,
    output logic out_valid
);

    logic [IDX_W-1:0] idx_c;
    logic             f_c;
    logic             out_valid_d;
    logic             out_valid_q;

    // Combinational table lookup
    always_comb begin
        idx_c = {x, y, z};
        f_c   = tt_eval(TRUTH_TABLE, idx_c);
    end

    // Valid flag tracks qualified inputs with one cycle of latency
    always_comb begin
        out_valid_d = in_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;

    if (REG_OUT) begin : g_reg_out
        logic out_d;
        logic out_q;

        // Result is captured only on qualified cycles, otherwise held
        always_comb begin
            out_d = out_q;
            if (in_valid) begin
                out_d = f_c;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                out_q <= 1'b0;
            end else begin
                out_q <= out_d;
            end
        end

        assign out = out_q;
    end else begin : g_comb_out
        assign out = f_c;
    end

endmodule

// File: tb/tb_project1_unit.sv
// Self-checking bench for project1_unit: majority (registered), XOR3 (registered)
// and majority (combinational output) instances share one randomized stimulus stream.
module tb_project1_unit;
    import project1_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic x = 1'b1, y = 1'b1, z = 1'b1;
    logic in_valid = 1'b1;

    logic out_maj, vld_maj;
    logic out_xor, vld_xor;
    logic out_cmb, vld_cmb;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int   due;
        logic maj;
        logic xr;
    } exp_t;

    exp_t q[$];
    bit   rst_cyc[int];
    logic last_maj = 1'b0;
    logic last_xor = 1'b0;

    project1_unit #(.TRUTH_TABLE(TT_MAJORITY), .REG_OUT(1'b1)) u_maj (
        .clk(clk), .rst(rst), .x(x), .y(y), .z(z), .in_valid(in_valid),
        .out(out_maj), .out_valid(vld_maj)
    );

    project1_unit #(.TRUTH_TABLE(TT_XOR3), .REG_OUT(1'b1)) u_xor (
        .clk(clk), .rst(rst), .x(x), .y(y), .z(z), .in_valid(in_valid),
        .out(out_xor), .out_valid(vld_xor)
    );

    project1_unit #(.TRUTH_TABLE(TT_MAJORITY), .REG_OUT(1'b0)) u_cmb (
        .clk(clk), .rst(rst), .x(x), .y(y), .z(z), .in_valid(in_valid),
        .out(out_cmb), .out_valid(vld_cmb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference functions from the arithmetic definitions
    function automatic logic ref_maj(input int k);
        int ones;
        ones = ((k >> 2) & 1) + ((k >> 1) & 1) + (k & 1);
        return (ones >= 2) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic ref_xor(input int k);
        int ones;
        ones = ((k >> 2) & 1) + ((k >> 1) & 1) + (k & 1);
        return ((ones % 2) == 1) ? 1'b1 : 1'b0;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and record the expected response
    task automatic drive(input bit r, input bit v, input int k);
        @(posedge clk);
        #1;
        rst      = r;
        in_valid = v;
        x        = 1'((k >> 2) & 1);
        y        = 1'((k >> 1) & 1);
        z        = 1'(k & 1);
        if (r) rst_cyc[cyc + 1] = 1'b1;
        else if (v) q.push_back('{due: cyc + 1, maj: ref_maj(k), xr: ref_xor(k)});
    endtask

    // Monitor: sample away from the active edge and compare against the scoreboard
    always @(negedge clk) begin
        logic exp_v;
        int   k_now;
        exp_v = 1'b0;
        if (q.size() > 0 && q[0].due < cyc) begin
            failures++;
            checks++;
            $display("FAIL stale_entry cyc=%0d due=%0d", cyc, q[0].due);
            void'(q.pop_front());
        end
        if (rst_cyc.exists(cyc)) begin
            last_maj = 1'b0;
            last_xor = 1'b0;
        end else if (q.size() > 0 && q[0].due == cyc) begin
            exp_v    = 1'b1;
            last_maj = q[0].maj;
            last_xor = q[0].xr;
            void'(q.pop_front());
        end
        chk("maj_valid", vld_maj, exp_v);
        chk("maj_out",   out_maj, last_maj);
        chk("xor_valid", vld_xor, exp_v);
        chk("xor_out",   out_xor, last_xor);
        chk("cmb_valid", vld_cmb, exp_v);
        k_now = {29'd0, x, y, z};
        chk("cmb_out",   out_cmb, ref_maj(k_now));
    end

    initial begin
        int k;
        bit r, v;
        rst_cyc[1] = 1'b1;
        // Second reset cycle with all inputs high and qualified
        drive(1'b1, 1'b1, 7);
        // Full sweep of the table
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, i);
        // Hold behaviour when input qualification drops
        drive(1'b0, 1'b1, 7);
        drive(1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 2);
        // Reset in the middle of a sweep
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, i);
        drive(1'b1, 1'b1, 4);
        for (int i = 5; i < 8; i++) drive(1'b0, 1'b1, i);
        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            k = int'($urandom_range(0, 7));
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 19) == 0);
            drive(r, v, k);
        end
        drive(1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", (q.size() == 0), 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
